gmii_rx_fcs_check: RTL and testbench

GMII_RX_FCS_CHECK -- requirements
Module: gmii_rx_fcs_check

---
 rtl/gmii_rx_fcs_check.sv | 166 ++++++++++++++++
 tb/tb_gmii_rx_fcs_check.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes with 1-cycle latency,
// checks the Ethernet FCS and length, and keeps saturating good/bad frame counters.
module gmii_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_en,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DROP} state_t;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

  // MSB-first register fed with each byte LSB first, i.e. the wire bit order.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        fresh_q, fresh_d;
  logic        out_en_q, out_en_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sof_q, out_sof_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  logic short_frm, frm_len_err, frm_crc_err;
  assign short_frm   = len_q < 16'd4;
  assign frm_len_err = short_frm || (len_q < MIN_L) || (len_q > MAX_L);
  assign frm_crc_err = short_frm || (crc_q != CRC_RESIDUE);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    crc_d        = crc_q;
    len_d        = len_q;
    fresh_d      = 1'b0;
    out_en_d     = 1'b0;
    out_data_d   = out_data_q;
    out_sof_d    = 1'b0;
    frame_done_d = 1'b0;
    crc_err_d    = crc_err_q;
    len_err_d    = len_err_q;
    frame_len_d  = frame_len_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    case (state_q)
      IDLE: begin
        // dv already high right after reset means we joined mid-frame: discard it.
        if (gmii_rx_dv) begin
          if (!fresh_q && gmii_rxd == 8'h55) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == 8'h55) begin
          if (pre_cnt_q == 3'd7) state_d = DROP;
          else pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (gmii_rxd == 8'hD5) begin
          state_d = FRAME;
          crc_d   = 32'hFFFFFFFF;
          len_d   = 16'd0;
        end else begin
          state_d = DROP;
        end
      end
      FRAME: begin
        if (gmii_rx_dv) begin
          out_en_d   = 1'b1;
          out_data_d = gmii_rxd;
          out_sof_d  = (len_q == 16'd0);
          crc_d      = crc_byte(crc_q, gmii_rxd);
          len_d      = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        end else begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          crc_err_d    = frm_crc_err;
          len_err_d    = frm_len_err;
          frame_len_d  = len_q;
          if (frm_crc_err || frm_len_err)
            bad_cnt_d = (bad_cnt_q == 16'hFFFF) ? bad_cnt_q : bad_cnt_q + 16'd1;
          else
            good_cnt_d = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
        end
      end
      default: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= 3'd0;
      crc_q        <= 32'hFFFFFFFF;
      len_q        <= 16'd0;
      fresh_q      <= 1'b1;
      out_en_q     <= 1'b0;
      out_data_q   <= 8'd0;
      out_sof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      frame_len_q  <= 16'd0;
      good_cnt_q   <= 16'd0;
      bad_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      fresh_q      <= fresh_d;
      out_en_q     <= out_en_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      frame_done_q <= frame_done_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
      frame_len_q  <= frame_len_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign out_en     = out_en_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign frame_done = frame_done_q;
  assign crc_err    = crc_err_q;
  assign len_err    = len_err_q;
  assign frame_len  = frame_len_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;
endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check: FCS is generated with the reflected Ethernet CRC,
// frame results are captured by a negedge monitor and compared to hand-derived values.
module tb_gmii_rx_fcs_check;
  logic        clk = 1'b0, rst = 1'b1, gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        out_en, out_sof, frame_done, crc_err, len_err;
  logic [7:0]  out_data;
  logic [15:0] frame_len, good_cnt, bad_cnt;

  always #5 clk = ~clk;

  gmii_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
    .out_en(out_en), .out_data(out_data), .out_sof(out_sof),
    .frame_done(frame_done), .crc_err(crc_err), .len_err(len_err),
    .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  typedef struct {
    logic        ce;
    logic        le;
    logic [15:0] flen;
    int          nen;
  } rec_t;

  int n_chk = 0, n_fail = 0;
  logic [7:0] frm[$];
  logic [7:0] exp_q[$];
  rec_t       done_q[$];
  int frame_pos = 0, data_err = 0, sof_err = 0, long_done = 0, overlap = 0;
  int tot_en = 0, tot_done = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) frame_pos = 0;
    if (out_en) begin
      tot_en++;
      frame_pos++;
      if (out_sof !== (frame_pos == 1)) sof_err++;
      if (exp_q.size() == 0) data_err++;
      else if (out_data !== exp_q.pop_front()) data_err++;
    end
    if (frame_done) begin
      rec_t r;
      r.ce = crc_err; r.le = len_err; r.flen = frame_len; r.nen = frame_pos;
      done_q.push_back(r);
      tot_done++;
      frame_pos = 0;
      if (out_en) overlap++;
      if (done_prev) long_done++;
    end
    done_prev = frame_done;
  end

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk); #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  // dv low with a preamble-looking byte on rxd: must be ignored
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h55);
  endtask

  task automatic build(input int n, input int seed, input bit with_fcs);
    logic [31:0] c;
    int nd;
    frm.delete();
    nd = with_fcs ? n - 4 : n;
    for (int i = 0; i < nd; i++) frm.push_back(8'((i * 13 + seed) & 255));
    if (with_fcs) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < nd; i++) begin
        c = c ^ {24'h0, frm[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      frm.push_back(c[7:0]); frm.push_back(c[15:8]);
      frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    end
  endtask

  task automatic send(input int npre);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (frm[i]) begin
      drive(1'b1, frm[i]);
      exp_q.push_back(frm[i]);
    end
    drive(1'b0, 8'h55);
  endtask

  task automatic expect_frame(input string tag, input logic ce, input logic le, input int flen);
    rec_t r;
    int t;
    t = 0;
    while (done_q.size() == 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (done_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = done_q.pop_front();
      chk({tag, "_crc_err"}, r.ce, ce);
      chk({tag, "_len_err"}, r.le, le);
      chk({tag, "_frame_len"}, r.flen, flen);
      chk({tag, "_out_en_cnt"}, r.nen, flen);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {out_en, out_sof, frame_done, crc_err, len_err, out_data}, 32'd0);
    chk("rst_frame_len", frame_len, 32'd0);
    chk("rst_counters", {good_cnt, bad_cnt}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    build(64, 1, 1'b1); send(7);
    expect_frame("good64", 1'b0, 1'b0, 64);
    idle(2);
    chk("good_cnt_1", good_cnt, 32'd1);
    chk("bad_cnt_0", bad_cnt, 32'd0);

    build(64, 1, 1'b1); frm[63] = frm[63] ^ 8'h01; send(7);
    expect_frame("bad_fcs", 1'b1, 1'b0, 64);
    idle(2);
    chk("bad_cnt_1", bad_cnt, 32'd1);

    build(60, 2, 1'b1); send(7);
    expect_frame("runt60", 1'b0, 1'b1, 60);
    build(2, 3, 1'b0); send(7);
    expect_frame("runt2", 1'b1, 1'b1, 2);
    idle(2);
    chk("bad_cnt_3", bad_cnt, 32'd3);
    chk("good_cnt_still_1", good_cnt, 32'd1);

    build(64, 4, 1'b1); send(3);
    expect_frame("pre3", 1'b0, 1'b0, 64);

    // bad preamble byte, then an SFD-like pattern that must still be dropped
    e0 = tot_en; d0 = tot_done;
    drive(1'b1, 8'h55); drive(1'b1, 8'h12);
    drive(1'b1, 8'h55); drive(1'b1, 8'hD5);
    build(20, 5, 1'b0);
    foreach (frm[i]) drive(1'b1, frm[i]);
    drive(1'b0, 8'h00); idle(5);
    chk("pre_bad_no_en", tot_en - e0, 32'd0);
    chk("pre_bad_no_done", tot_done - d0, 32'd0);

    repeat (4) drive(1'b1, 8'h55);
    drive(1'b0, 8'h00); idle(5);
    chk("pre_drop_no_done", tot_done - d0, 32'd0);

    build(64, 10, 1'b1); send(7);
    expect_frame("after_drop", 1'b0, 1'b0, 64);
    idle(2);
    chk("good_cnt_3", good_cnt, 32'd3);

    // reset at frame byte 30 with dv held high; the tail starts with a fake preamble
    build(64, 6, 1'b1);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, frm[i]);
      exp_q.push_back(frm[i]);
    end
    @(posedge clk); #1;
    rst = 1'b1; gmii_rxd = frm[30];
    #1;
    chk("rst_mid_outputs", {out_en, frame_done, out_data}, 32'd0);
    chk("rst_mid_counters", {good_cnt, bad_cnt, frame_len}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; gmii_rxd = 8'h55;
    exp_q.delete();
    e0 = tot_en; d0 = tot_done;
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'hD5);
    for (int i = 31; i < 64; i++) drive(1'b1, frm[i]);
    drive(1'b0, 8'h00);
    build(64, 7, 1'b1); send(7);
    expect_frame("post_rst", 1'b0, 1'b0, 64);
    idle(2);
    chk("post_rst_en_cnt", tot_en - e0, 32'd64);
    chk("post_rst_done_cnt", tot_done - d0, 32'd1);
    chk("post_rst_good_cnt", good_cnt, 32'd1);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    build(1518, 8, 1'b1); send(7); send(7);
    expect_frame("b2b_a", 1'b0, 1'b0, 1518);
    expect_frame("b2b_b", 1'b0, 1'b0, 1518);
    idle(2);
    chk("b2b_good_cnt", good_cnt, 32'd2);

    build(1519, 9, 1'b1); send(7);
    expect_frame("oversize", 1'b0, 1'b1, 1519);
    idle(2);
    chk("oversize_bad_cnt", bad_cnt, 32'd1);

    chk("data_mismatches", data_err, 32'd0);
    chk("sof_errors", sof_err, 32'd0);
    chk("done_wider_than_1", long_done, 32'd0);
    chk("done_with_out_en", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
